// File: rtl/seg_msg_pkg.sv
// Shared definitions for the seven-segment message scroller:
// character codes, display modes and the fixed message table.
package seg_msg_pkg;

    typedef logic [4:0] char_t;

    localparam char_t C_0     = 5'd0;
    localparam char_t C_1     = 5'd1;
    localparam char_t C_2     = 5'd2;
    localparam char_t C_3     = 5'd3;
    localparam char_t C_4     = 5'd4;
    localparam char_t C_5     = 5'd5;
    localparam char_t C_6     = 5'd6;
    localparam char_t C_7     = 5'd7;
    localparam char_t C_8     = 5'd8;
    localparam char_t C_9     = 5'd9;
    localparam char_t C_A     = 5'd10;
    localparam char_t C_C     = 5'd11;
    localparam char_t C_E     = 5'd12;
    localparam char_t C_F     = 5'd13;
    localparam char_t C_G     = 5'd14;
    localparam char_t C_H     = 5'd15;
    localparam char_t C_I     = 5'd16;
    localparam char_t C_L     = 5'd17;
    localparam char_t C_O     = 5'd18;
    localparam char_t C_P     = 5'd19;
    localparam char_t C_R     = 5'd20;
    localparam char_t C_S     = 5'd21;
    localparam char_t C_U     = 5'd22;
    localparam char_t C_BLANK = 5'd31;

    typedef enum logic [1:0] {
        MODE_STEP   = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam int ROM_CHARS = 16;

    // Message table: 8 messages x 16 characters, padded with blanks.
    // The scroller only reads the first MSG_LEN characters of the first NUM_MSG rows.
    function automatic char_t msg_rom(input logic [2:0] m, input logic [3:0] i);
        char_t row [ROM_CHARS];
        for (int k = 0; k < ROM_CHARS; k++) row[k] = C_BLANK;
        case (m)
            3'd0: begin  // "HELLO"
                row[0] = C_H; row[1] = C_E; row[2] = C_L; row[3] = C_L; row[4] = C_O;
            end
            3'd1: begin  // "PROG"
                row[0] = C_P; row[1] = C_R; row[2] = C_O; row[3] = C_G;
            end
            3'd2: begin  // "CAFE 42"
                row[0] = C_C; row[1] = C_A; row[2] = C_F; row[3] = C_E;
                row[5] = C_4; row[6] = C_2;
            end
            3'd3: begin  // "GUS 0815"
                row[0] = C_G; row[1] = C_U; row[2] = C_S;
                row[4] = C_0; row[5] = C_8; row[6] = C_1; row[7] = C_5;
            end
            3'd4: begin  // "31415926"
                row[0] = C_3; row[1] = C_1; row[2] = C_4; row[3] = C_1;
                row[4] = C_5; row[5] = C_9; row[6] = C_2; row[7] = C_6;
            end
            3'd5: begin  // "SOAP"
                row[0] = C_S; row[1] = C_O; row[2] = C_A; row[3] = C_P;
            end
            3'd6: begin  // "PILE"
                row[0] = C_P; row[1] = C_I; row[2] = C_L; row[3] = C_E;
            end
            default: begin  // "HI 7"
                row[0] = C_H; row[1] = C_I; row[3] = C_7;
            end
        endcase
        return row[i];
    endfunction

endpackage

// File: rtl/seg_msg_scroller_glyph.sv
// Character code to seven-segment pattern {g,f,e,d,c,b,a}, active-high.
// Codes without a glyph (including blank) produce an unlit digit.
module seg_glyph_decoder
    import seg_msg_pkg::*;
(
    input  char_t       code_i,
    output logic [6:0]  seg_o
);

    // Pure lookup; default keeps undefined codes dark.
    always_comb begin
        seg_o = 7'h00;
        case (code_i)
            C_0: seg_o = 7'h3F;
            C_1: seg_o = 7'h06;
            C_2: seg_o = 7'h5B;
            C_3: seg_o = 7'h4F;
            C_4: seg_o = 7'h66;
            C_5: seg_o = 7'h6D;
            C_6: seg_o = 7'h7D;
            C_7: seg_o = 7'h07;
            C_8: seg_o = 7'h7F;
            C_9: seg_o = 7'h6F;
            C_A: seg_o = 7'h77;
            C_C: seg_o = 7'h39;
            C_E: seg_o = 7'h79;
            C_F: seg_o = 7'h71;
            C_G: seg_o = 7'h3D;
            C_H: seg_o = 7'h76;
            C_I: seg_o = 7'h06;
            C_L: seg_o = 7'h38;
            C_O: seg_o = 7'h3F;
            C_P: seg_o = 7'h73;
            C_R: seg_o = 7'h50;
            C_S: seg_o = 7'h6D;
            C_U: seg_o = 7'h3E;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg_msg_scroller.sv
// Scrolls one of NUM_MSG stored messages across a single seven-segment
// digit. A prescaler produces a step tick every 2^speed clocks; the mode
// decides how the character index moves on each tick.
module seg_msg_scroller
    import seg_msg_pkg::*;
#(
    parameter int MSG_LEN = 8,
    parameter int NUM_MSG = 4,
    parameter int DIV_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    input  logic [3:0]                 speed,
    input  logic [1:0]                 mode,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [$clog2(MSG_LEN)-1:0] char_idx,
    output logic                       wrap
);

    localparam int IDX_W = $clog2(MSG_LEN);
    localparam int SEL_W = $clog2(NUM_MSG);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             phase_q, phase_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             wrap_q, wrap_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [4:0]       spd_c;
    logic [DIV_W-1:0] lim_c;
    logic             tick_c;
    mode_e            mode_c;
    char_t            code_c;
    logic [6:0]       glyph_c;

    // Speed exponent clamped so the period always fits the prescaler.
    always_comb begin
        spd_c = {1'b0, speed};
        if (spd_c > 5'(DIV_W - 1)) spd_c = 5'(DIV_W - 1);
    end

    assign lim_c  = (DIV_W'(1) << spd_c) - DIV_W'(1);
    assign tick_c = en && (presc_q == lim_c);
    assign mode_c = mode_e'(mode);
    assign code_c = msg_rom(3'(sel_q), 4'(idx_q));

    seg_glyph_decoder u_glyph (
        .code_i (code_c),
        .seg_o  (glyph_c)
    );

    // Next-state: message switch has priority and swallows any tick in that cycle.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        if (en) begin
            if (msg_sel != sel_q) begin
                sel_d   = msg_sel;
                presc_d = '0;
                idx_d   = '0;
                dir_d   = 1'b1;
                phase_d = 1'b0;
            end else begin
                presc_d = tick_c ? '0 : presc_q + DIV_W'(1);
                if (tick_c) begin
                    // Any tick outside BLINK clears a phase left over from BLINK.
                    phase_d = 1'b0;
                    case (mode_c)
                        MODE_STEP, MODE_BLINK: begin
                            if (mode_c == MODE_BLINK) phase_d = ~phase_q;
                            if (mode_c == MODE_STEP || phase_q) begin
                                if (idx_q == LAST) begin
                                    idx_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end
                        end
                        MODE_BOUNCE: begin
                            if (dir_q) begin
                                if (idx_q == LAST) begin
                                    dir_d  = 1'b0;
                                    idx_d  = idx_q - IDX_W'(1);
                                    wrap_d = 1'b1;
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    dir_d  = 1'b1;
                                    idx_d  = IDX_W'(1);
                                    wrap_d = 1'b1;
                                end else begin
                                    idx_d = idx_q - IDX_W'(1);
                                end
                            end
                        end
                        MODE_HOLD: ;
                    endcase
                end
            end
        end
    end

    // Display drive lags the index by one register; blank when disabled or in the BLINK off-phase.
    always_comb begin
        seg_d = (en && !phase_q) ? glyph_c : 7'h00;
        dp_d  = en && !phase_q && (idx_q == LAST);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b1;
            phase_q <= 1'b0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign char_idx = idx_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Bench for seg_msg_scroller: directed scenarios with literal expectations
// plus randomized traffic, all checked against a text-level message model.
module tb_seg_msg_scroller;

    localparam int MSG_LEN = 8;
    localparam int NUM_MSG = 4;
    localparam int DIV_W   = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] msg_sel = 2'd0;
    logic [3:0] speed = 4'd0;
    logic [1:0] mode = 2'd0;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] char_idx;
    logic       wrap;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    string msgs [NUM_MSG];
    int    m_presc, m_idx, m_sel;
    bit    m_dir, m_phase;
    int    e_seg, e_dp, e_wrap;

    seg_msg_scroller #(.MSG_LEN(MSG_LEN), .NUM_MSG(NUM_MSG), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .msg_sel  (msg_sel),
        .speed    (speed),
        .mode     (mode),
        .seg      (seg),
        .dp       (dp),
        .char_idx (char_idx),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic int glyph_of(byte c);
        case (c)
            "0": return 'h3F;  "1": return 'h06;  "2": return 'h5B;  "3": return 'h4F;
            "4": return 'h66;  "5": return 'h6D;  "6": return 'h7D;  "7": return 'h07;
            "8": return 'h7F;  "9": return 'h6F;  "A": return 'h77;  "C": return 'h39;
            "E": return 'h79;  "F": return 'h71;  "G": return 'h3D;  "H": return 'h76;
            "I": return 'h06;  "L": return 'h38;  "O": return 'h3F;  "P": return 'h73;
            "R": return 'h50;  "S": return 'h6D;  "U": return 'h3E;
            default: return 0;
        endcase
    endfunction

    function automatic int char_glyph(int s, int i);
        string t;
        t = msgs[s];
        if (i < t.len()) return glyph_of(t[i]);
        return 0;
    endfunction

    task automatic m_reset();
        m_presc = 0; m_idx = 0; m_sel = 0; m_dir = 1'b1; m_phase = 1'b0;
        e_seg = 0; e_dp = 0; e_wrap = 0;
    endtask

    task automatic m_advance();
        m_idx = (m_idx + 1) % MSG_LEN;
        if (m_idx == 0) e_wrap = 1;
    endtask

    task automatic m_bounce();
        if (m_dir) begin
            if (m_idx == MSG_LEN - 1) begin m_dir = 1'b0; m_idx = m_idx - 1; e_wrap = 1; end
            else m_idx = m_idx + 1;
        end else begin
            if (m_idx == 0) begin m_dir = 1'b1; m_idx = 1; e_wrap = 1; end
            else m_idx = m_idx - 1;
        end
    endtask

    // One clock of the model, using the inputs present at the rising edge.
    task automatic m_step();
        int  sp;
        int  period;
        bit  tk;
        if (!reset_n) begin m_reset(); return; end
        if (!en) begin e_seg = 0; e_dp = 0; e_wrap = 0; return; end
        e_seg  = m_phase ? 0 : char_glyph(m_sel, m_idx);
        e_dp   = (!m_phase && m_idx == MSG_LEN - 1) ? 1 : 0;
        e_wrap = 0;
        if (int'(msg_sel) != m_sel) begin
            m_sel = int'(msg_sel); m_presc = 0; m_idx = 0; m_dir = 1'b1; m_phase = 1'b0;
        end else begin
            sp     = (int'(speed) > DIV_W - 1) ? DIV_W - 1 : int'(speed);
            period = 1 << sp;
            tk     = (m_presc == period - 1);
            m_presc = tk ? 0 : (m_presc + 1) % (1 << DIV_W);
            if (tk) begin
                case (mode)
                    2'b00: begin m_phase = 1'b0; m_advance(); end
                    2'b01: begin if (m_phase) m_advance(); m_phase = !m_phase; end
                    2'b10: begin m_phase = 1'b0; m_bounce(); end
                    default: m_phase = 1'b0;
                endcase
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Advance one clock and compare every output with the model.
    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("char_idx", char_idx, m_idx);
        chk("wrap", wrap, e_wrap);
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("async_seg", seg, 0);
        chk("async_idx", char_idx, 0);
        chk("async_wrap", wrap, 0);
        chk("async_dp", dp, 0);
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int lit_hello [8];
        int lit_prog [4];
        int lit_bounce [15];
        int lit_blink [8];
        lit_hello  = '{'h76, 'h79, 'h38, 'h38, 'h3F, 0, 0, 0};
        lit_prog   = '{'h73, 'h50, 'h3F, 'h3D};
        lit_bounce = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        lit_blink  = '{'h73, 0, 'h50, 0, 'h3F, 0, 'h3D, 0};
        msgs[0] = "HELLO";
        msgs[1] = "PROG";
        msgs[2] = "CAFE 42";
        msgs[3] = "GUS 0815";
        m_reset();

        // Reset held
        cycle();
        cycle();
        reset_n = 1'b1;

        // HELLO at full speed
        en = 1'b1; msg_sel = 2'd0; speed = 4'd0; mode = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("lit_hello_seg", seg, lit_hello[k-1]);
            chk("lit_hello_idx", char_idx, k % 8);
            chk("lit_hello_wrap", wrap, (k == 8) ? 1 : 0);
            chk("lit_hello_dp", dp, (k == 8) ? 1 : 0);
        end

        // Step every 4 clocks, then back to every clock
        speed = 4'd2;
        for (int j = 1; j <= 16; j++) begin
            cycle();
            chk("lit_speed2_idx", char_idx, (j / 4) % 8);
        end
        speed = 4'd0;
        for (int j = 1; j <= 4; j++) begin
            cycle();
            chk("lit_speed0_idx", char_idx, (4 + j) % 8);
        end

        // Message switch at index 3
        for (int j = 0; j < 3; j++) cycle();
        chk("lit_pre_sel_idx", char_idx, 3);
        msg_sel = 2'd1;
        cycle();
        chk("lit_sel_idx", char_idx, 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("lit_prog_seg", seg, lit_prog[k]);
        end

        // Bounce from index 0
        msg_sel = 2'd0; mode = 2'b10;
        cycle();
        chk("lit_bounce_start", char_idx, 0);
        for (int k = 0; k < 15; k++) begin
            cycle();
            chk("lit_bounce_idx", char_idx, lit_bounce[k]);
            chk("lit_bounce_wrap", wrap, (k == 7 || k == 14) ? 1 : 0);
        end

        // Blink on PROG
        msg_sel = 2'd1; mode = 2'b01;
        cycle();
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("lit_blink_seg", seg, lit_blink[k-1]);
            chk("lit_blink_idx", char_idx, k / 2);
        end

        // Reset in the middle of a message, then enable freeze
        msg_sel = 2'd0; mode = 2'b00;
        cycle();
        for (int j = 0; j < 5; j++) cycle();
        chk("lit_pre_reset_idx", char_idx, 5);
        async_reset();
        for (int j = 0; j < 3; j++) cycle();
        chk("lit_post_reset_idx", char_idx, 3);
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            cycle();
            chk("lit_frozen_idx", char_idx, 3);
            chk("lit_frozen_seg", seg, 0);
        end
        en = 1'b1;
        cycle();
        chk("lit_resume_idx", char_idx, 4);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 39) == 0) msg_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if (m_presc == 0 && $urandom_range(0, 19) == 0) speed = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) async_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
